// File: rtl/mask_scan_pkg.sv
// mask_scan_pkg
// Shared constants and helpers for the mask scan pipeline.
//   GROUP      : lanes handled by one mask_scan_group slice
//   GCW / GFW  : width of a group-local count (0..8) and a group-local lane index (0..7)
//   cwidth()   : count width needed to hold 0..width
//   prefix_lsb(): lsb of lane i's field inside a packed prefix vector
package mask_scan_pkg;

    localparam int GROUP = 8;
    localparam int GCW   = 4;
    localparam int GFW   = 3;

    function automatic int cwidth(input int width);
        return $clog2(width) + 1;
    endfunction

    function automatic int prefix_lsb(input int lane, input int cw);
        return lane * cw;
    endfunction

endpackage

// File: rtl/mask_scan_group.sv
// mask_scan_group
// Purely combinational scan of one 8-lane slice of a thread mask.
// Ports:
//   lanes : 8 lane bits, bit i = lane i of this group
//   cnt   : number of set lanes (0..8)
//   pre   : 8 packed 3-bit fields, field i = set lanes among 0..i-1 of this group
//   ffs   : index of the lowest set lane, 0 when the group is empty
//   empty : no lane set
module mask_scan_group
    import mask_scan_pkg::*;
(
    input  logic [GROUP-1:0]     lanes,
    output logic [GCW-1:0]       cnt,
    output logic [GROUP*GFW-1:0] pre,
    output logic [GFW-1:0]       ffs,
    output logic                 empty
);

    logic [GCW-1:0] acc;
    logic           found;

    // An exclusive prefix never exceeds 7 inside a group, so only the low
    // three bits of the running count are stored per field.
    always_comb begin
        acc   = '0;
        found = 1'b0;
        pre   = '0;
        ffs   = '0;
        for (int i = 0; i < GROUP; i++) begin
            pre[i*GFW +: GFW] = acc[GFW-1:0];
            if (lanes[i] && !found) begin
                ffs   = GFW'(i);
                found = 1'b1;
            end
            acc = acc + GCW'(lanes[i]);
        end
        cnt   = acc;
        empty = !found;
    end

endmodule

// File: rtl/mask_scan_pipe.sv
// mask_scan_pipe
// Elastic, back-pressurable scan of per-warp thread masks: popcount, any-active,
// lowest set lane and per-lane exclusive prefix count, with a sideband tag.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : input handshake
//   in_mask, in_zeros     : lane mask; in_zeros scans ~in_mask instead
//   in_tag                : sideband carried with the beat
//   out_valid/out_ready   : output handshake, outputs hold while stalled
//   out_pcnt, out_any     : set-lane count and count != 0
//   out_ffs               : lowest set lane, 0 when none
//   out_prefix            : field i (bits [i*CWIDTH +: CWIDTH]) = set lanes 0..i-1
//   out_tag               : tag of this result
// STAGES=1 registers the full combinational result once; STAGES=2 registers the
// group-local results first and merges the groups in the second stage.
module mask_scan_pipe
    import mask_scan_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CWIDTH = cwidth(WIDTH),
    parameter int STAGES = 2,
    parameter int TAG_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_mask,
    input  logic                     in_zeros,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CWIDTH-1:0]        out_pcnt,
    output logic                     out_any,
    output logic [CWIDTH-2:0]        out_ffs,
    output logic [WIDTH*CWIDTH-1:0]  out_prefix,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int NG = WIDTH / GROUP;
    localparam int FW = CWIDTH - 1;

    logic [WIDTH-1:0]       scan_mask;
    logic [GCW-1:0]         g_cnt   [NG];
    logic [GROUP*GFW-1:0]   g_pre   [NG];
    logic [GFW-1:0]         g_ffs   [NG];
    logic [NG-1:0]          g_empty;

    logic [GCW-1:0]         c_cnt   [NG];
    logic [GROUP*GFW-1:0]   c_pre   [NG];
    logic [GFW-1:0]         c_ffs   [NG];
    logic [NG-1:0]          c_empty;
    logic                   feed_valid;
    logic [TAG_W-1:0]       feed_tag;

    logic                   take_out;
    logic [CWIDTH-1:0]      r_pcnt;
    logic [FW-1:0]          r_ffs;
    logic [WIDTH*CWIDTH-1:0] r_prefix;
    logic [CWIDTH-1:0]      acc;
    logic                   found;

    assign scan_mask = in_zeros ? ~in_mask : in_mask;

    for (genvar gi = 0; gi < NG; gi++) begin : g_group
        mask_scan_group u_group (
            .lanes (scan_mask[gi*GROUP +: GROUP]),
            .cnt   (g_cnt[gi]),
            .pre   (g_pre[gi]),
            .ffs   (g_ffs[gi]),
            .empty (g_empty[gi])
        );
    end

    // The output register can take a new result when it is empty or is
    // being consumed this cycle.
    assign take_out = !out_valid || out_ready;

    if (STAGES == 2) begin : g_two_stage
        logic                 s0_v;
        logic [GCW-1:0]       s0_cnt   [NG];
        logic [GROUP*GFW-1:0] s0_pre   [NG];
        logic [GFW-1:0]       s0_ffs   [NG];
        logic [NG-1:0]        s0_empty;
        logic [TAG_W-1:0]     s0_tag;

        assign in_ready   = !s0_v || take_out;
        assign feed_valid = s0_v;
        assign feed_tag   = s0_tag;
        assign c_cnt      = s0_cnt;
        assign c_pre      = s0_pre;
        assign c_ffs      = s0_ffs;
        assign c_empty    = s0_empty;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s0_v     <= 1'b0;
                s0_empty <= '0;
                s0_tag   <= '0;
                for (int g = 0; g < NG; g++) begin
                    s0_cnt[g] <= '0;
                    s0_pre[g] <= '0;
                    s0_ffs[g] <= '0;
                end
            end else if (in_ready) begin
                s0_v <= in_valid;
                if (in_valid) begin
                    s0_empty <= g_empty;
                    s0_tag   <= in_tag;
                    for (int g = 0; g < NG; g++) begin
                        s0_cnt[g] <= g_cnt[g];
                        s0_pre[g] <= g_pre[g];
                        s0_ffs[g] <= g_ffs[g];
                    end
                end
            end
        end
    end else begin : g_one_stage
        assign in_ready   = take_out;
        assign feed_valid = in_valid;
        assign feed_tag   = in_tag;
        assign c_cnt      = g_cnt;
        assign c_pre      = g_pre;
        assign c_ffs      = g_ffs;
        assign c_empty    = g_empty;
    end

    // Merge groups: each group's local prefixes are offset by the total of
    // all lower groups, and ffs comes from the lowest non-empty group.
    always_comb begin
        acc      = '0;
        found    = 1'b0;
        r_ffs    = '0;
        r_prefix = '0;
        for (int g = 0; g < NG; g++) begin
            for (int j = 0; j < GROUP; j++) begin
                r_prefix[prefix_lsb(g*GROUP + j, CWIDTH) +: CWIDTH] =
                    acc + CWIDTH'(c_pre[g][j*GFW +: GFW]);
            end
            if (!found && !c_empty[g]) begin
                r_ffs = FW'(g*GROUP) + FW'(c_ffs[g]);
                found = 1'b1;
            end
            acc = acc + CWIDTH'(c_cnt[g]);
        end
        r_pcnt = acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_pcnt   <= '0;
            out_any    <= 1'b0;
            out_ffs    <= '0;
            out_prefix <= '0;
            out_tag    <= '0;
        end else if (take_out) begin
            out_valid <= feed_valid;
            if (feed_valid) begin
                out_pcnt   <= r_pcnt;
                out_any    <= (r_pcnt != '0);
                out_ffs    <= r_ffs;
                out_prefix <= r_prefix;
                out_tag    <= feed_tag;
            end
        end
    end

endmodule

// File: tb/tb_mask_scan_pipe.sv
// tb_mask_scan_pipe
// Drives two instances side by side: A (WIDTH=32, STAGES=2) and B (WIDTH=64,
// STAGES=1). Expected results come from a lane-counting model applied to the
// beats recorded at acceptance, checked in FIFO order at each output transfer.
module tb_mask_scan_pipe;

    localparam int AW = 32, AS = 2, ACW = 6;
    localparam int BW = 64, BS = 1, BCW = 7;

    typedef struct {
        logic [63:0] mask;
        logic        zeros;
        logic [7:0]  tag;
        int          cyc;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;

    logic              a_in_valid, a_in_ready, a_in_zeros, a_out_valid, a_out_ready, a_out_any;
    logic [AW-1:0]     a_in_mask;
    logic [7:0]        a_in_tag, a_out_tag;
    logic [ACW-1:0]    a_out_pcnt;
    logic [ACW-2:0]    a_out_ffs;
    logic [AW*ACW-1:0] a_out_prefix;

    logic              b_in_valid, b_in_ready, b_in_zeros, b_out_valid, b_out_ready, b_out_any;
    logic [BW-1:0]     b_in_mask;
    logic [7:0]        b_in_tag, b_out_tag;
    logic [BCW-1:0]    b_out_pcnt;
    logic [BCW-2:0]    b_out_ffs;
    logic [BW*BCW-1:0] b_out_prefix;

    beat_t qa[$];
    beat_t qb[$];
    int    cyc = 0;
    bit    exact_lat = 1'b0;
    int    n_checks = 0;
    int    n_fail = 0;
    logic [511:0] snap_a, snap_b;

    always #5 clk = ~clk;

    mask_scan_pipe #(.WIDTH(AW), .STAGES(AS), .TAG_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mask(a_in_mask),
        .in_zeros(a_in_zeros), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pcnt(a_out_pcnt),
        .out_any(a_out_any), .out_ffs(a_out_ffs), .out_prefix(a_out_prefix),
        .out_tag(a_out_tag)
    );

    mask_scan_pipe #(.WIDTH(BW), .STAGES(BS), .TAG_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mask(b_in_mask),
        .in_zeros(b_in_zeros), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pcnt(b_out_pcnt),
        .out_any(b_out_any), .out_ffs(b_out_ffs), .out_prefix(b_out_prefix),
        .out_tag(b_out_tag)
    );

    task automatic check_output(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_mask(input beat_t b, input int w);
        logic [63:0] wm;
        wm = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        return (b.zeros ? ~b.mask : b.mask) & wm;
    endfunction

    task automatic check_beat(input string who, input int w, input int cw, input int st,
                              input beat_t b, input logic [6:0] pcnt, input logic any,
                              input logic [5:0] ffs, input logic [447:0] prefix,
                              input logic [7:0] tag);
        logic [63:0]  m;
        logic [447:0] exp_pre;
        int           exp_pcnt, exp_ffs, below;
        m        = model_mask(b, w);
        exp_pcnt = $countones(m);
        exp_ffs  = 0;
        for (int i = w - 1; i >= 0; i--) if (m[i]) exp_ffs = i;
        exp_pre = '0;
        for (int i = 0; i < w; i++) begin
            below = $countones(m & ((64'd1 << i) - 64'd1));
            for (int k = 0; k < cw; k++) exp_pre[i*cw + k] = below[k];
        end
        check_output({who, "_pcnt"},   512'(pcnt),   512'(exp_pcnt));
        check_output({who, "_any"},    512'(any),    512'(exp_pcnt != 0));
        check_output({who, "_ffs"},    512'(ffs),    512'(exp_ffs));
        check_output({who, "_prefix"}, 512'(prefix), 512'(exp_pre));
        check_output({who, "_tag"},    512'(tag),    512'(b.tag));
        if (exact_lat) check_output({who, "_latency"}, 512'(cyc - b.cyc), 512'(st));
    endtask

    // One clock cycle: record accepted beats, check consumed results, advance.
    task automatic tick();
        beat_t nb, eb;
        #1;
        if (a_in_valid && a_in_ready) begin
            nb.mask = 64'(a_in_mask); nb.zeros = a_in_zeros; nb.tag = a_in_tag; nb.cyc = cyc;
            qa.push_back(nb);
        end
        if (b_in_valid && b_in_ready) begin
            nb.mask = b_in_mask; nb.zeros = b_in_zeros; nb.tag = b_in_tag; nb.cyc = cyc;
            qb.push_back(nb);
        end
        if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) check_output("a_unexpected", 512'(a_out_valid), '0);
            else begin
                eb = qa.pop_front();
                check_beat("a", AW, ACW, AS, eb, 7'(a_out_pcnt), a_out_any, 6'(a_out_ffs),
                           448'(a_out_prefix), a_out_tag);
            end
        end
        if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) check_output("b_unexpected", 512'(b_out_valid), '0);
            else begin
                eb = qb.pop_front();
                check_beat("b", BW, BCW, BS, eb, b_out_pcnt, b_out_any, b_out_ffs,
                           b_out_prefix, b_out_tag);
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic apply_stimulus(input bit av, input logic [31:0] am, input bit az, input logic [7:0] at,
                                  input bit bv, input logic [63:0] bm, input bit bz, input logic [7:0] bt);
        a_in_valid = av; a_in_mask = am; a_in_zeros = az; a_in_tag = at;
        b_in_valid = bv; b_in_mask = bm; b_in_zeros = bz; b_in_tag = bt;
    endtask

    task automatic random_stimulus(input bit av, input bit bv);
        logic [31:0] am;
        logic [63:0] bm;
        case ($urandom % 8)
            0:       begin am = '0; bm = '0; end
            1:       begin am = '1; bm = '1; end
            default: begin am = $urandom; bm = {$urandom, $urandom}; end
        endcase
        apply_stimulus(av, am, ($urandom % 4) == 0, 8'($urandom),
                       bv, bm, ($urandom % 4) == 0, 8'($urandom));
    endtask

    task automatic check_reset_outputs(input string phase);
        check_output({phase, "_a_valid"},  512'(a_out_valid),  '0);
        check_output({phase, "_a_pcnt"},   512'(a_out_pcnt),   '0);
        check_output({phase, "_a_any"},    512'(a_out_any),    '0);
        check_output({phase, "_a_ffs"},    512'(a_out_ffs),    '0);
        check_output({phase, "_a_prefix"}, 512'(a_out_prefix), '0);
        check_output({phase, "_a_tag"},    512'(a_out_tag),    '0);
        check_output({phase, "_b_valid"},  512'(b_out_valid),  '0);
        check_output({phase, "_b_pcnt"},   512'(b_out_pcnt),   '0);
        check_output({phase, "_b_prefix"}, 512'(b_out_prefix), '0);
        check_output({phase, "_b_tag"},    512'(b_out_tag),    '0);
    endtask

    // Present one beat to A with the output stalled and stop once its
    // result should be showing; the caller then checks fields directly.
    task automatic send_hold_a(input logic [31:0] mask, input bit zeros, input logic [7:0] tag);
        a_out_ready = 1'b0;
        apply_stimulus(1'b1, mask, zeros, tag, 1'b0, '0, 1'b0, '0);
        tick();
        a_in_valid = 1'b0;
        for (int i = 0; i < AS - 1; i++) tick();
        #1;
        check_output("a_directed_valid", 512'(a_out_valid), 512'(1));
    endtask

    task automatic release_a();
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
    endtask

    task automatic drain();
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) tick();
        check_output("a_drained", 512'(qa.size()), '0);
        check_output("b_drained", 512'(qb.size()), '0);
    endtask

    initial begin
        rst_n = 1'b0;
        apply_stimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        a_out_ready = 1'b0; b_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        #1;
        check_output("a_ready_after_reset", 512'(a_in_ready), 512'(1));
        check_output("b_ready_after_reset", 512'(b_in_ready), 512'(1));

        // Directed boundary beats on A
        send_hold_a(32'h0000_0000, 1'b0, 8'h11);
        check_output("zero_pcnt",   512'(a_out_pcnt),   '0);
        check_output("zero_any",    512'(a_out_any),    '0);
        check_output("zero_ffs",    512'(a_out_ffs),    '0);
        check_output("zero_prefix", 512'(a_out_prefix), '0);
        release_a();

        send_hold_a(32'hF0F0_0100, 1'b0, 8'h5A);
        check_output("f0_pcnt",     512'(a_out_pcnt),           512'(9));
        check_output("f0_ffs",      512'(a_out_ffs),            512'(8));
        check_output("f0_prefix9",  512'(a_out_prefix[54 +: 6]),  512'(1));
        check_output("f0_prefix31", 512'(a_out_prefix[186 +: 6]), 512'(8));
        check_output("f0_tag",      512'(a_out_tag),            512'(8'h5A));
        release_a();

        send_hold_a(32'hFFFF_FFFF, 1'b1, 8'h22);
        check_output("inv_ones_pcnt", 512'(a_out_pcnt), '0);
        check_output("inv_ones_any",  512'(a_out_any),  '0);
        release_a();

        send_hold_a(32'hFFFF_FFFE, 1'b1, 8'h33);
        check_output("inv_fe_pcnt", 512'(a_out_pcnt), 512'(1));
        check_output("inv_fe_ffs",  512'(a_out_ffs),  '0);
        check_output("inv_fe_any",  512'(a_out_any),  512'(1));
        release_a();

        send_hold_a(32'hFFFF_FFFF, 1'b0, 8'h44);
        check_output("ones_pcnt",     512'(a_out_pcnt),             512'(32));
        check_output("ones_ffs",      512'(a_out_ffs),              '0);
        check_output("ones_prefix31", 512'(a_out_prefix[186 +: 6]), 512'(31));
        release_a();

        // Full-rate stream: one beat per cycle, latency exactly STAGES
        exact_lat = 1'b1;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            random_stimulus(1'b1, 1'b1);
            #1;
            check_output("a_stream_ready", 512'(a_in_ready), 512'(1));
            check_output("b_stream_ready", 512'(b_in_ready), 512'(1));
            tick();
        end
        drain();
        exact_lat = 1'b0;

        // Random valid/ready on both sides
        for (int i = 0; i < 150; i++) begin
            random_stimulus(($urandom % 4) != 0, ($urandom % 4) != 0);
            a_out_ready = ($urandom % 3) != 0;
            b_out_ready = ($urandom % 3) != 0;
            tick();
        end
        drain();

        // Stall with continuous input: only STAGES beats get in
        a_out_ready = 1'b0; b_out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            random_stimulus(1'b1, 1'b1);
            #1;
            if (i == 3) begin
                snap_a = 512'({a_out_valid, a_out_pcnt, a_out_any, a_out_ffs, a_out_prefix, a_out_tag});
                snap_b = 512'({b_out_valid, b_out_pcnt, b_out_any, b_out_ffs, b_out_prefix, b_out_tag});
            end else if (i > 3) begin
                check_output("a_stall_stable",
                    512'({a_out_valid, a_out_pcnt, a_out_any, a_out_ffs, a_out_prefix, a_out_tag}), snap_a);
                check_output("b_stall_stable",
                    512'({b_out_valid, b_out_pcnt, b_out_any, b_out_ffs, b_out_prefix, b_out_tag}), snap_b);
            end
            if (i >= 3) begin
                check_output("a_stall_ready", 512'(a_in_ready), '0);
                check_output("b_stall_ready", 512'(b_in_ready), '0);
            end
            tick();
        end
        check_output("a_stall_accepted", 512'(qa.size()), 512'(AS));
        check_output("b_stall_accepted", 512'(qb.size()), 512'(BS));
        drain();

        // Reset with beats in flight: nothing may emerge afterwards
        a_out_ready = 1'b0; b_out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            random_stimulus(1'b1, 1'b1);
            tick();
        end
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        qa.delete();
        qb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_output("a_ready_after_midreset", 512'(a_in_ready), 512'(1));
        check_output("b_ready_after_midreset", 512'(b_in_ready), 512'(1));
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            #1;
            check_output("a_no_stale", 512'(a_out_valid), '0);
            check_output("b_no_stale", 512'(b_out_valid), '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
